// File: rtl/intt_gs_butterfly.sv
// Inverse-NTT Gentleman-Sande butterfly: xout = (x+y) mod P, yout = ((x-y)*w) mod P, Barrett-reduced.
// Five stages, or six with INTT_SCALE_EN (halves both results mod P); output backpressure stalls the whole pipe.
module intt_gs_butterfly #(
    parameter int DW = 12,
    parameter int P  = 3329,
    parameter int MU = 5039
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] xin,
    input  logic [DW-1:0] yin,
    input  logic [DW-1:0] wr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] xout,
    output logic [DW-1:0] yout,
    output logic          busy
);
    localparam int MW = $clog2(MU + 1);
    localparam int TW = DW + 1 + MW;
    localparam logic [DW-1:0] P_D  = DW'(P);
    localparam logic [DW:0]   P_D1 = (DW+1)'(P);
    localparam logic [DW+1:0] P_D2 = (DW+2)'(P);
    localparam logic [TW-1:0] P_T  = TW'(P);
    localparam logic [TW-1:0] MU_T = TW'(MU);

    logic stall, en, accept;
    assign stall    = out_valid & ~out_ready;
    assign en       = ~stall;
    assign in_ready = ~stall;
    assign accept   = in_valid & in_ready;

    // S1: modular sum and difference of the inputs
    logic [DW:0]   sum_w, dif_w;
    logic [DW-1:0] s_c, d_c;
    assign sum_w = {1'b0, xin} + {1'b0, yin};
    assign dif_w = {1'b0, xin} - {1'b0, yin} + P_D1;
    assign s_c   = DW'((sum_w >= P_D1) ? sum_w - P_D1 : sum_w);
    assign d_c   = DW'((dif_w >= P_D1) ? dif_w - P_D1 : dif_w);

    logic          v1, v2, v3, v4, v5;
    logic [DW-1:0] s1, d1, w1, s2, s3, s4, x5, y5;
    logic [2*DW-1:0] z2;
    logic [DW+1:0] z3, r0_4;
    logic [TW-1:0] t3;

    // z only matters mod 2^(DW+2) once the quotient estimate is formed
    logic [2*DW-1:0] z_c;
    logic [TW-1:0]   t_c;
    logic [DW+1:0]   r0_c, r1_c;
    logic [DW-1:0]   r_c;
    assign z_c  = {{DW{1'b0}}, d1} * {{DW{1'b0}}, w1};
    assign t_c  = {{MW{1'b0}}, z2[2*DW-1:DW-1]} * MU_T;
    assign r0_c = z3 - (DW+2)'((t3 >> (DW + 1)) * P_T);
    assign r1_c = (r0_4 >= P_D2) ? r0_4 - P_D2 : r0_4;
    assign r_c  = DW'((r1_c >= P_D2) ? r1_c - P_D2 : r1_c);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {v1, v2, v3, v4, v5} <= '0;
            s1 <= '0; d1 <= '0; w1 <= '0;
            s2 <= '0; z2 <= '0;
            s3 <= '0; z3 <= '0; t3 <= '0;
            s4 <= '0; r0_4 <= '0;
            x5 <= '0; y5 <= '0;
        end else if (en) begin
            v1 <= accept;
            s1 <= s_c;
            d1 <= d_c;
            w1 <= wr;
            v2 <= v1;
            s2 <= s1;
            z2 <= z_c;
            v3 <= v2;
            s3 <= s2;
            z3 <= z2[DW+1:0];
            t3 <= t_c;
            v4 <= v3;
            s4 <= s3;
            r0_4 <= r0_c;
            v5 <= v4;
            x5 <= s4;
            y5 <= r_c;
        end
    end

`ifdef INTT_SCALE_EN
    function automatic logic [DW-1:0] half_mod(input logic [DW-1:0] v);
        logic [DW:0] h;
        h = {1'b0, v} + (v[0] ? {1'b0, P_D} : '0);
        return DW'(h >> 1);
    endfunction

    logic          v6;
    logic [DW-1:0] x6, y6;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v6 <= 1'b0;
            x6 <= '0;
            y6 <= '0;
        end else if (en) begin
            v6 <= v5;
            x6 <= half_mod(x5);
            y6 <= half_mod(y5);
        end
    end
    assign out_valid = v6;
    assign xout      = x6;
    assign yout      = y6;
    assign busy      = v1 | v2 | v3 | v4 | v5 | v6;
`else
    assign out_valid = v5;
    assign xout      = x5;
    assign yout      = y5;
    assign busy      = v1 | v2 | v3 | v4 | v5;
`endif
endmodule

// File: tb/tb_intt_gs_butterfly.sv
// Directed and streamed checks of intt_gs_butterfly (default P=3329, DW=12).
module tb_intt_gs_butterfly;
    localparam int P = 3329;
`ifdef INTT_SCALE_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 5;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [11:0] xin, yin, wr, xout, yout;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intt_gs_butterfly dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .xin(xin), .yin(yin), .wr(wr),
        .out_valid(out_valid), .out_ready(out_ready),
        .xout(xout), .yout(yout), .busy(busy)
    );

    function automatic logic [11:0] fix(input int v);
`ifdef INTT_SCALE_EN
        return 12'((v % 2 == 1) ? (v + P) / 2 : v / 2);
`else
        return 12'(v);
`endif
    endfunction

    function automatic logic [23:0] golden(input int x, input int y, input int w);
        return {fix((x + y) % P), fix(((x - y + P) * w) % P)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        xin = '0; yin = '0; wr = '0;
        #23;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
        checks++;
        if (xout !== 12'd0 || yout !== 12'd0) begin
            errors++;
            $display("FAIL reset_data: xout=%0d yout=%0d, want 0 0", xout, yout);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
        end
    endtask

    task automatic test_directed();
        int tx[6], ty[6], tw[6], ex[6], ey[6];
        int lat;
        logic [11:0] gx, gy;
        tx = '{5, 3, 3328, 0, 1000, 4};
        ty = '{3, 5, 3328, 1, 1000, 3};
        tw = '{1, 1, 17, 3328, 5, 1};
`ifdef INTT_SCALE_EN
        ex = '{4, 4, 3328, 1665, 1000, 1668};
        ey = '{1, 3328, 0, 1665, 0, 1665};
`else
        ex = '{8, 8, 3327, 1, 2000, 7};
        ey = '{2, 3327, 0, 1, 0, 1};
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            xin = 12'(tx[i]); yin = 12'(ty[i]); wr = 12'(tw[i]);
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            gx = xout; gy = yout;
            checks++;
            if (lat != LAT) begin
                errors++;
                $display("FAIL latency[%0d]: got %0d clk, want %0d", i, lat, LAT);
            end
            checks++;
            if (gx !== 12'(ex[i])) begin
                errors++;
                $display("FAIL xout[%0d]: got %0d, want %0d", i, gx, ex[i]);
            end
            checks++;
            if (gy !== 12'(ey[i])) begin
                errors++;
                $display("FAIL yout[%0d]: got %0d, want %0d", i, gy, ey[i]);
            end
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL valid_pulse[%0d]: out_valid=%b one clk later, want 0", i, out_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp_q[$];
        logic [23:0] e;
        logic [11:0] hx, hy;
        logic prev_stall;
        int sent, rcv, stalls, xv, yv, wv;
        sent = 0; rcv = 0; stalls = 0; prev_stall = 1'b0; hx = '0; hy = '0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            @(posedge clk); #1;
            out_ready = !(c >= 7 && c <= 9);
            xv = 100 * sent + 7; yv = 50 * sent + 400; wv = sent + 2;
            in_valid = (sent < 8);
            xin = 12'(xv); yin = 12'(yv); wr = 12'(wv);
            #1;
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL b2b_in_ready c=%0d: in_ready=%b, want %b", c, in_ready, !(out_valid && !out_ready));
            end
            if (prev_stall) begin
                checks++;
                if (xout !== hx || yout !== hy) begin
                    errors++;
                    $display("FAIL b2b_hold c=%0d: got %0d/%0d, want %0d/%0d", c, xout, yout, hx, hy);
                end
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) begin
                stalls++; hx = xout; hy = yout;
            end
            if (out_valid && out_ready) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
                if ({xout, yout} !== e) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %0d/%0d, want %0d/%0d", rcv, xout, yout, e[23:12], e[11:0]);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(xv, yv, wv));
                sent++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (rcv != 8 || sent != 8 || stalls != 3) begin
            errors++;
            $display("FAIL b2b_count: sent=%0d rcv=%0d stalls=%0d, want 8 8 3", sent, rcv, stalls);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: busy=%b out_valid=%b, want 0 0", busy, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            xin = 12'(10 + i); yin = 12'(i); wr = 12'd9;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midrst_busy_before: busy=%b, want 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: out_valid=%b busy=%b, want 0 0", out_valid, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_stale c=%0d: out_valid=%b busy=%b, want 0 0", i, out_valid, busy);
            end
        end
    endtask

    task automatic test_random();
        logic [23:0] exp_q[$];
        logic [23:0] e;
        int sent, rcv, xv, yv, wv;
        sent = 0; rcv = 0;
        for (int c = 0; c < 50000 && (sent < 10000 || exp_q.size() > 0); c++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(3, 0) != 0);
            xv = int'($urandom_range(P - 1, 0));
            yv = int'($urandom_range(P - 1, 0));
            wv = int'($urandom_range(P - 1, 0));
            in_valid = (sent < 10000);
            xin = 12'(xv); yin = 12'(yv); wr = 12'(wv);
            #1;
            if (out_valid && out_ready) begin
                checks++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hFFFFFF;
                if ({xout, yout} !== e) begin
                    errors++;
                    $display("FAIL rand_result[%0d]: got %0d/%0d, want %0d/%0d", rcv, xout, yout, e[23:12], e[11:0]);
                end
                rcv++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(golden(xv, yv, wv));
                sent++;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        checks++;
        if (rcv != 10000 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL rand_count: rcv=%0d pending=%0d, want 10000 0", rcv, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/intt_gs_butterfly.md
Name: intt_gs_butterfly

Overview:
- Pipelined inverse-NTT radix-2 Gentleman-Sande butterfly: xout = (x + y) mod P, yout = ((x - y) * w) mod P.
- Counterpart of the forward Cooley-Tukey butterfly. It is instantiated per lane in the INTT datapath, fed by the coefficient memory and the inverse twiddle ROM.
- Modular product uses a pipelined Barrett reduction, so no vendor multiplier IP is needed.
- Handshake is valid/ready, with a global pipeline stall on output backpressure.

Parameters:
- DW, 12, coefficient width in bits. P must be less than 2^DW.
- P, 3329, prime modulus.
- MU, 5039, Barrett constant, floor(2^(2*DW) / P). It must match P and DW.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  input operand set valid
- in_ready  output  1  block accepts an operand set this cycle
- xin  input  DW  upper coefficient, must be less than P
- yin  input  DW  lower coefficient, must be less than P
- wr  input  DW  inverse twiddle, must be less than P
- out_valid  output  1  xout/yout valid
- out_ready  input  1  downstream accepts the result
- xout  output  DW  (x + y) mod P
- yout  output  DW  ((x - y) * w) mod P
- busy  output  1  at least one pipeline stage holds valid data

Behaviour:
- Reset: clock is clk; reset rst_n is asynchronous and active-low. On reset, all stage valid bits, data registers, xout, yout, out_valid and busy go to 0. in_ready is 1 after reset.
- Stall and handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - Accept occurs when in_valid & in_ready.
  - While stall is high, every stage register and every valid bit holds.
  - Bubbles are not collapsed.
- Pipeline, 5 stages. Latency is 5 clk from acceptance to out_valid when there is no stall.
  - S1: s = x + y; if s >= P then s -= P. d = x - y + P; if d >= P then d -= P. Compute in DW+1 bits. Register s, d, w.
  - S2: z = d * w, 2*DW bits. s is delayed alongside.
  - S3: t = (z >> (DW-1)) * MU. Register t and z.
  - S4: q = t >> (DW+1). r0 = z - q*P, kept in DW+2 bits, guaranteed in [0, 3P).
  - S5: r1 = r0 - P if r0 >= P, else r0. r = r1 - P if r1 >= P, else r1. Register xout = s and yout = r.
- Throughput is 1 operand set per clk when out_ready is held high.
- Ordering: results leave strictly in acceptance order, with no drop or duplication under any out_ready pattern.
- A valid bit moves with each stage. out_valid equals the S5 valid bit.
- xout/yout hold their value while stall is high. When out_valid is 0, their value is don't-care but deterministic, namely the last value.
- busy is the OR of all stage valid bits.
- Boundaries:
  - x = y gives yout = 0.
  - x < y wraps through +P.
  - x + y = 2P - 2 (the maximum) reduces to P - 2.
  - d = P - 1 with w = P - 1 gives 1.
- Reset mid-operation: all in-flight data is discarded, and nothing emerges after release.
- Operands at or above P are outside the contract; the result for them is unspecified.

Optional Feature:
- Macro INTT_SCALE_EN.
- When defined: adds stage S6, which halves both results mod P (multiplication by 2^-1) so that a log2(N)-stage INTT needs no final N^-1 scaling.
  - v even gives v/2; v odd gives (v + P)/2, computed in DW+1 bits.
  - Latency becomes 6.
  - The stall and valid rules extend unchanged to S6.
- When undefined: 5 stages and unscaled outputs, exactly as in Behaviour.

Test Plan:
- Reset, then x=5, y=3, w=1, out_ready=1: xout=8, yout=2, out_valid exactly 5 clk after acceptance and high for 1 clk.
- x=3, y=5, w=1: xout=8, yout=3327 (subtraction wrap). x=3328, y=3328, w=17: xout=3327, yout=0.
- x=0, y=1, w=3328: xout=1, yout=1 (d=3328, and 3328*3328 mod 3329 = 1, the Barrett worst case). Also a 10k-vector random sweep checked against a golden model, with zero mismatches.
- Back-to-back stream of 8 sets with out_ready low for 3 clk mid-stream:
  - in_ready is low exactly while out_valid & ~out_ready.
  - All 8 results arrive in order, none lost or repeated.
  - xout/yout are stable during the stall.
- With 3 sets in flight, pulse rst_n low for 1 clk: out_valid and busy drop to 0 immediately, and no stale result appears within 10 clk after release.
- INTT_SCALE_EN defined:
  - x=5, y=3, w=1 gives xout=4, yout=1.
  - x=4, y=3, w=1 gives xout=1668, yout=1665.
  - Latency is 6 clk.
